// File: rtl/vram_write_queue_pkg.sv
// Shared VRAM geometry, controller FSM states
// and the queued write-entry layout.
package vram_write_queue_pkg;

  localparam int VRAM_AW    = 14;
  localparam int VRAM_DW    = 16;
  localparam int VRAM_WORDS = 16384;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] data;
  } wr_ent_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count;
// push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + (AW+1)'(do_push)
                   - (AW+1)'(do_pop);
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/vram_write_queue.sv
// Arbitrates one single-port VRAM between scanout reads,
// queued CPU writes and a full-memory fill.
module vram_write_queue
  import vram_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [VRAM_AW-1:0] wr_addr,
  input  logic [VRAM_DW-1:0] wr_data,
  input  logic               clr_start,
  input  logic [VRAM_DW-1:0] clr_value,
  output logic               clr_busy,
  input  logic               rd_req,
  input  logic [VRAM_AW-1:0] rd_addr,
  output logic [VRAM_DW-1:0] rd_data,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic [VRAM_DW-1:0] ram_wdata,
  output logic               ram_we,
  input  logic [VRAM_DW-1:0] ram_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e             state_q, state_d;
  logic [VRAM_AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [VRAM_DW-1:0] clr_val_q, clr_val_d;

  wr_ent_t            fifo_din, head;
  logic               full, empty;
  logic [CW-1:0]      count, cnt_nxt;
  logic               push, pop, fill;

  assign fifo_din = '{addr: wr_addr, data: wr_data};

  sync_fifo #(
    .W     ($bits(wr_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign wr_ready = !full && (state_q == ST_IDLE);
  assign clr_busy = (state_q != ST_IDLE);
  assign rd_data  = ram_rdata;

  // reads always win, so a same-address write simply waits
  assign push = wr_valid && wr_ready;
  assign fill = !rd_req && (state_q == ST_CLEAR);
  assign pop  = !rd_req && (state_q != ST_CLEAR) && !empty;

  assign cnt_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    ram_addr  = rd_addr;
    ram_wdata = head.data;
    ram_we    = 1'b0;
    unique case (1'b1)
      rd_req: ram_addr = rd_addr;
      fill: begin
        ram_addr  = clr_ptr_q;
        ram_wdata = clr_val_q;
        ram_we    = 1'b1;
      end
      pop: begin
        ram_addr  = head.addr;
        ram_wdata = head.data;
        ram_we    = 1'b1;
      end
      default: ram_we = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_val_d = clr_val_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          clr_val_d = clr_value;
          clr_ptr_d = '0;
          state_d   = (cnt_nxt != '0) ? ST_DRAIN
                                      : ST_CLEAR;
        end
      end
      ST_DRAIN: begin
        if (cnt_nxt == '0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (fill) begin
          clr_ptr_d = clr_ptr_q + 1'b1;
          if (clr_ptr_q == VRAM_AW'(VRAM_WORDS - 1))
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
      clr_val_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      clr_val_q <= clr_val_d;
    end
  end

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue with a
// behavioural 1-cycle-latency VRAM attached.
module tb_vram_write_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        wr_valid;
  logic        wr_ready;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        clr_start;
  logic [15:0] clr_value;
  logic        clr_busy;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic [15:0] rd_data;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  logic [15:0] vmem [16384];

  int n_chk;
  int n_fail;

  vram_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_value (clr_value),
    .clr_busy  (clr_busy),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) vmem[ram_addr] <= ram_wdata;
    ram_rdata <= vmem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_value = '0;
    rd_req = 1'b0; rd_addr = '0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wr_ready: got %b exp 1", wr_ready);
    end
    n_chk++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_clr_busy: got %b exp 0", clr_busy);
    end
    n_chk++;
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ram_we: got %b exp 0", ram_we);
    end
    tick();
    n_chk++;
    if (ram_we !== 1'b0 || ram_addr !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_idle_port: we %b addr %h exp 0/0000",
               ram_we, ram_addr);
    end
  endtask

  task automatic test_push3();
    logic [13:0] av [3];
    logic [15:0] dv [3];
    av = '{14'h0010, 14'h0011, 14'h0012};
    dv = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr = av[i];
      wr_data = dv[i];
      #1;
      n_chk++;
      if (wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL push3_ready[%0d]: got %b exp 1", i, wr_ready);
      end
      tick();
      n_chk++;
      if (ram_we !== 1'b1 || ram_addr !== av[i] || ram_wdata !== dv[i]) begin
        n_fail++;
        $display("FAIL push3_emit[%0d]: got we %b %h/%h exp 1 %h/%h",
                 i, ram_we, ram_addr, ram_wdata, av[i], dv[i]);
      end
    end
    wr_valid = 1'b0;
    tick();
    n_chk++;
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL push3_done: ram_we got %b exp 0", ram_we);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (vmem[av[i]] !== dv[i]) begin
        n_fail++;
        $display("FAIL push3_mem[%0d]: got %h exp %h",
                 i, vmem[av[i]], dv[i]);
      end
    end
  endtask

  task automatic test_rd_block();
    // old word at 0x20 so a same-address read can be checked
    wr_valid = 1'b1;
    wr_addr = 14'h0020;
    wr_data = 16'h5555;
    tick();
    wr_valid = 1'b0;
    tick();
    rd_req = 1'b1;
    rd_addr = 14'h0020;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_addr = 14'(32 + i);
      wr_data = 16'(16'h1000 + i);
      #1;
      n_chk++;
      if (wr_ready !== (i < DEPTH)) begin
        n_fail++;
        $display("FAIL rdblk_ready[%0d]: got %b exp %b",
                 i, wr_ready, (i < DEPTH));
      end
      n_chk++;
      if (ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL rdblk_we[%0d]: got %b exp 0", i, ram_we);
      end
      tick();
    end
    wr_valid = 1'b0;
    #1;
    n_chk++;
    if (rd_data !== 16'h5555) begin
      n_fail++;
      $display("FAIL rdblk_old_data: got %h exp 5555", rd_data);
    end
    rd_req = 1'b0;
    #1;
    for (int j = 0; j < DEPTH; j++) begin
      n_chk++;
      if (ram_we !== 1'b1 || ram_addr !== 14'(32 + j)
          || ram_wdata !== 16'(16'h1000 + j)) begin
        n_fail++;
        $display("FAIL rdblk_emit[%0d]: got we %b %h/%h exp 1 %h/%h",
                 j, ram_we, ram_addr, ram_wdata,
                 14'(32 + j), 16'(16'h1000 + j));
      end
      tick();
    end
    n_chk++;
    if (ram_we !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rdblk_after: we %b ready %b exp 0/1",
               ram_we, wr_ready);
    end
  endtask

  task automatic test_clear_full();
    int cnt;
    int err;
    clr_value = 16'h3F3F;
    clr_start = 1'b1;
    #1;
    n_chk++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_pre_busy: got %b exp 0", clr_busy);
    end
    tick();
    clr_start = 1'b0;
    #1;
    n_chk++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0
        || ram_wdata !== 16'h3F3F || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_first: we %b %h/%h rdy %b exp 1 0000/3f3f 0",
               ram_we, ram_addr, ram_wdata, wr_ready);
    end
    cnt = 0;
    while (clr_busy && cnt < 20000) begin
      cnt++;
      tick();
    end
    n_chk++;
    if (cnt !== 16384) begin
      n_fail++;
      $display("FAIL clr_busy_len: got %0d exp 16384", cnt);
    end
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_end_ready: got %b exp 1", wr_ready);
    end
    err = 0;
    for (int a = 0; a < 16384; a++)
      if (vmem[a] !== 16'h3F3F) err++;
    n_chk++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL clr_fill: %0d bad words exp 0", err);
    end
  endtask

  task automatic test_clear_rd();
    int cnt;
    int nrd;
    int perr;
    int err;
    bit first;
    wr_valid = 1'b1;
    wr_addr = 14'h3000;
    wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    tick();
    clr_value = 16'h00C3;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    rd_addr = 14'h3000;
    cnt = 0;
    nrd = 0;
    perr = 0;
    first = 1'b1;
    while (clr_busy && cnt < 20000) begin
      rd_req = (cnt % 8 == 7);
      #1;
      if (rd_req ? (ram_we !== 1'b0) : (ram_we !== 1'b1)) perr++;
      if (rd_req) nrd++;
      cnt++;
      tick();
      if (rd_req && first) begin
        first = 1'b0;
        n_chk++;
        if (rd_data !== 16'h1234) begin
          n_fail++;
          $display("FAIL clrrd_old: got %h exp 1234", rd_data);
        end
      end
    end
    rd_req = 1'b0;
    n_chk++;
    if (cnt !== 16384 + nrd) begin
      n_fail++;
      $display("FAIL clrrd_len: got %0d exp %0d", cnt, 16384 + nrd);
    end
    n_chk++;
    if (perr !== 0) begin
      n_fail++;
      $display("FAIL clrrd_pause: %0d bad cycles exp 0", perr);
    end
    err = 0;
    for (int a = 0; a < 16384; a++)
      if (vmem[a] !== 16'h00C3) err++;
    n_chk++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL clrrd_fill: %0d bad words exp 0", err);
    end
  endtask

  task automatic test_drain_clear();
    int cnt;
    int err;
    rd_req = 1'b1;
    rd_addr = 14'h0;
    wr_valid = 1'b1;
    wr_addr = 14'h0050;
    wr_data = 16'h1111;
    tick();
    wr_addr = 14'h0051;
    wr_data = 16'h2222;
    clr_value = 16'hABCD;
    clr_start = 1'b1;
    #1;
    n_chk++;
    if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_push_start: rdy %b busy %b exp 1/0",
               wr_ready, clr_busy);
    end
    tick();
    wr_valid = 1'b0;
    clr_start = 1'b0;
    rd_req = 1'b0;
    #1;
    n_chk++;
    if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_busy: busy %b rdy %b exp 1/0",
               clr_busy, wr_ready);
    end
    n_chk++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0050
        || ram_wdata !== 16'h1111) begin
      n_fail++;
      $display("FAIL drain_w0: we %b %h/%h exp 1 0050/1111",
               ram_we, ram_addr, ram_wdata);
    end
    tick();
    n_chk++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0051
        || ram_wdata !== 16'h2222) begin
      n_fail++;
      $display("FAIL drain_w1: we %b %h/%h exp 1 0051/2222",
               ram_we, ram_addr, ram_wdata);
    end
    tick();
    n_chk++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0
        || ram_wdata !== 16'hABCD || vmem[14'h0051] !== 16'h2222) begin
      n_fail++;
      $display("FAIL drain_fill0: we %b %h/%h mem51 %h exp 1 0000/abcd 2222",
               ram_we, ram_addr, ram_wdata, vmem[14'h0051]);
    end
    cnt = 2;
    while (clr_busy && cnt < 20000) begin
      clr_start = (cnt == 100);
      clr_value = 16'h0F0F;
      cnt++;
      tick();
    end
    clr_start = 1'b0;
    n_chk++;
    if (cnt !== 2 + 16384) begin
      n_fail++;
      $display("FAIL drain_len: got %0d exp %0d", cnt, 2 + 16384);
    end
    err = 0;
    for (int a = 0; a < 16384; a++)
      if (vmem[a] !== 16'hABCD) err++;
    n_chk++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL drain_fill: %0d bad words exp 0", err);
    end
  endtask

  task automatic test_reset_mid_clear();
    clr_value = 16'h7777;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (16'h1000) tick();
    n_chk++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h1000) begin
      n_fail++;
      $display("FAIL rstmid_ptr: we %b addr %h exp 1 1000",
               ram_we, ram_addr);
    end
    resetn = 1'b0;
    tick();
    n_chk++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: busy %b rdy %b we %b exp 0/1/0",
               clr_busy, wr_ready, ram_we);
    end
    resetn = 1'b1;
    tick();
    n_chk++;
    if (ram_we !== 1'b0 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_empty: we %b busy %b exp 0/0",
               ram_we, clr_busy);
    end
    n_chk++;
    if (vmem[14'h0FFF] !== 16'h7777 || vmem[14'h1001] !== 16'hABCD) begin
      n_fail++;
      $display("FAIL rstmid_mem: fff %h 1001 %h exp 7777/abcd",
               vmem[14'h0FFF], vmem[14'h1001]);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_push3();
    test_rd_block();
    test_clear_full();
    test_clear_rd();
    test_drain_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
